// File: rtl/transform_butterfly_dit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transform_pkg
//  Description : Shared widths, typedefs and latency for the DIT butterfly.
//  Revision    : 1.0 - initial release
// ============================================================================
package transform_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_POINT        = DEF_WIDTH - 1;
    localparam int BFLY_DIT_LATENCY = 4;

    typedef logic signed [2*DEF_WIDTH-1:0] cplx_t;
    typedef logic signed [DEF_WIDTH:0]     wide_t;
    typedef logic signed [DEF_WIDTH+1:0]   out_t;
    typedef logic signed [2*DEF_WIDTH:0]   prod_t;

endpackage
`default_nettype wire

// File: rtl/transform_butterfly_dit_if.sv
`default_nettype none
// ============================================================================
//  Module      : transform_butterfly_dit_if
//  Description : Input/output valid-ready streams of the DIT butterfly.
//  Revision    : 1.0 - initial release
// ============================================================================
interface transform_butterfly_dit_if #(
    parameter int WIDTH = 16
);
    logic                          s_valid;
    logic                          s_ready;
    logic [2:0][2*WIDTH-1:0]       s_data;
    logic                          m_valid;
    logic                          m_ready;
    logic [1:0][2*WIDTH+3:0]       m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface
`default_nettype wire

// File: rtl/transform_butterfly_dit_twiddle_multiply.sv
`default_nettype none
// ============================================================================
//  Module      : transform_twiddle_multiply
//  Description : Complex b*w with round-half-up, scaling and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module transform_twiddle_multiply
    import transform_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int POINT = WIDTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [2*WIDTH-1:0]      i_b,
    input  logic [2*WIDTH-1:0]      i_w,
    output logic                    o_valid,
    output logic signed [WIDTH:0]   o_q_re,
    output logic signed [WIDTH:0]   o_q_im,
    output logic                    o_sat
);
    localparam int PROD_W = 2*WIDTH + 1;
    localparam int MUL_W  = 2*WIDTH;
    localparam logic signed [PROD_W-1:0] RND    = {{(PROD_W-1){1'b0}}, 1'b1} << (POINT-1);
    localparam logic signed [WIDTH:0]    Q_MAX  = {1'b0, {WIDTH{1'b1}}};
    localparam logic signed [WIDTH:0]    Q_MIN  = {1'b1, {WIDTH{1'b0}}};

    logic signed [MUL_W-1:0]  w_b_re, w_b_im, w_w_re, w_w_im;
    logic signed [MUL_W-1:0]  rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;
    logic signed [PROD_W-1:0] pr_d, pr_q, pi_d, pi_q;
    logic                     v1_d, v1_q, v2_d, v2_q;
    logic                     w_sat_re, w_sat_im;

    assign w_b_re = {{WIDTH{i_b[WIDTH-1]}},   i_b[WIDTH-1:0]};
    assign w_b_im = {{WIDTH{i_b[2*WIDTH-1]}}, i_b[2*WIDTH-1:WIDTH]};
    assign w_w_re = {{WIDTH{i_w[WIDTH-1]}},   i_w[WIDTH-1:0]};
    assign w_w_im = {{WIDTH{i_w[2*WIDTH-1]}}, i_w[2*WIDTH-1:WIDTH]};

    function automatic logic signed [PROD_W-1:0] sext(input logic signed [MUL_W-1:0] x);
        return {x[MUL_W-1], x};
    endfunction

    // Rounding and the arithmetic shift are folded into the S2 register so
    // the saturate stage only has to inspect the bits above the result.
    always_comb begin
        rr_d = rr_q;
        ii_d = ii_q;
        ri_d = ri_q;
        ir_d = ir_q;
        pr_d = pr_q;
        pi_d = pi_q;
        v1_d = v1_q;
        v2_d = v2_q;
        if (i_en) begin
            rr_d = w_b_re * w_w_re;
            ii_d = w_b_im * w_w_im;
            ri_d = w_b_re * w_w_im;
            ir_d = w_b_im * w_w_re;
            v1_d = i_valid;
            pr_d = (sext(rr_q) - sext(ii_q) + RND) >>> POINT;
            pi_d = (sext(ri_q) + sext(ir_q) + RND) >>> POINT;
            v2_d = v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    always_ff @(posedge clk) begin
        rr_q <= rr_d;
        ii_q <= ii_d;
        ri_q <= ri_d;
        ir_q <= ir_d;
        pr_q <= pr_d;
        pi_q <= pi_d;
    end

    // Result fits only when everything above it is pure sign extension.
    assign w_sat_re = !((&pr_q[PROD_W-1:WIDTH]) || !(|pr_q[PROD_W-1:WIDTH]));
    assign w_sat_im = !((&pi_q[PROD_W-1:WIDTH]) || !(|pi_q[PROD_W-1:WIDTH]));

    assign o_q_re  = w_sat_re ? (pr_q[PROD_W-1] ? Q_MIN : Q_MAX) : pr_q[WIDTH:0];
    assign o_q_im  = w_sat_im ? (pi_q[PROD_W-1] ? Q_MIN : Q_MAX) : pi_q[WIDTH:0];
    assign o_sat   = w_sat_re | w_sat_im;
    assign o_valid = v2_q;

endmodule
`default_nettype wire

// File: rtl/transform_butterfly_dit.sv
`default_nettype none
// ============================================================================
//  Module      : transform_butterfly_dit
//  Description : Radix-2 DIT butterfly y0 = a + b*w, y1 = a - b*w, 4-stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module transform_butterfly_dit
    import transform_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int POINT = WIDTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    transform_butterfly_dit_if.slave     bus,
    output logic                         overflow
);
    localparam int OUT_W = WIDTH + 2;

    logic                          w_en;
    logic                          v0_d, v0_q;
    logic [2*WIDTH-1:0]            a0_d, a0_q, b0_d, b0_q, w0_d, w0_q;
    logic [2*WIDTH-1:0]            a1_d, a1_q, a2_d, a2_q;
    logic                          m_valid_d, m_valid_q;
    logic [1:0][2*OUT_W-1:0]       m_data_d, m_data_q;
    logic                          overflow_d, overflow_q;

    logic                          w_v2, w_sat;
    logic signed [WIDTH:0]         w_q_re, w_q_im;
    logic signed [OUT_W-1:0]       w_a_re, w_a_im, w_qx_re, w_qx_im;
    logic signed [OUT_W-1:0]       w_y0_re, w_y0_im, w_y1_re, w_y1_im;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign w_en        = !m_valid_q || bus.m_ready;
    assign bus.s_ready = w_en;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign overflow    = overflow_q;

    transform_twiddle_multiply #(
        .WIDTH (WIDTH),
        .POINT (POINT)
    ) u_twiddle (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_valid (v0_q),
        .i_b     (b0_q),
        .i_w     (w0_q),
        .o_valid (w_v2),
        .o_q_re  (w_q_re),
        .o_q_im  (w_q_im),
        .o_sat   (w_sat)
    );

    assign w_a_re  = {{2{a2_q[WIDTH-1]}},   a2_q[WIDTH-1:0]};
    assign w_a_im  = {{2{a2_q[2*WIDTH-1]}}, a2_q[2*WIDTH-1:WIDTH]};
    assign w_qx_re = {w_q_re[WIDTH], w_q_re};
    assign w_qx_im = {w_q_im[WIDTH], w_q_im};
    assign w_y0_re = w_a_re + w_qx_re;
    assign w_y0_im = w_a_im + w_qx_im;
    assign w_y1_re = w_a_re - w_qx_re;
    assign w_y1_im = w_a_im - w_qx_im;

    always_comb begin
        v0_d       = v0_q;
        a0_d       = a0_q;
        b0_d       = b0_q;
        w0_d       = w0_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        overflow_d = overflow_q;
        if (w_en) begin
            v0_d        = bus.s_valid;
            a0_d        = bus.s_data[0];
            b0_d        = bus.s_data[1];
            w0_d        = bus.s_data[2];
            a1_d        = a0_q;
            a2_d        = a1_q;
            m_valid_d   = w_v2;
            m_data_d[0] = {w_y0_im, w_y0_re};
            m_data_d[1] = {w_y1_im, w_y1_re};
            overflow_d  = overflow_q | (w_v2 & w_sat);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            v0_q       <= v0_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        a0_q     <= a0_d;
        b0_q     <= b0_d;
        w0_q     <= w0_d;
        a1_q     <= a1_d;
        a2_q     <= a2_d;
        m_data_q <= m_data_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_transform_butterfly_dit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transform_butterfly_dit
//  Description : Self-checking bench for the DIT butterfly against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transform_butterfly_dit;
    import transform_pkg::*;

    localparam int W  = 16;
    localparam int P  = 15;
    localparam int OW = W + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic overflow;
    always #5 clk = ~clk;

    transform_butterfly_dit_if #(.WIDTH(W)) bus ();

    transform_butterfly_dit #(
        .WIDTH (W),
        .POINT (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .overflow (overflow)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [71:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [71:0] prev_data;
    logic [71:0] last_out;
    bit          got_out;
    bit          accepted;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint scale(input longint p);
        longint q;
        q = (p + (longint'(1) <<< (P-1))) >>> P;
        if (q > (longint'(1) <<< W) - 1) q = (longint'(1) <<< W) - 1;
        if (q < -(longint'(1) <<< W))    q = -(longint'(1) <<< W);
        return q;
    endfunction

    // y0 = a + b*w, y1 = a - b*w on plain integers.
    function automatic logic [71:0] model(input cplx_t a, input cplx_t b, input cplx_t w);
        longint ar, ai, br, bi, wr, wi, qr, qi;
        logic [OW-1:0] y0r, y0i, y1r, y1i;
        ar = longint'($signed(a[W-1:0]));
        ai = longint'($signed(a[2*W-1:W]));
        br = longint'($signed(b[W-1:0]));
        bi = longint'($signed(b[2*W-1:W]));
        wr = longint'($signed(w[W-1:0]));
        wi = longint'($signed(w[2*W-1:W]));
        qr = scale(br*wr - bi*wi);
        qi = scale(br*wi + bi*wr);
        y0r = OW'(ar + qr);
        y0i = OW'(ai + qi);
        y1r = OW'(ar - qr);
        y1i = OW'(ai - qi);
        return {y1i, y1r, y0i, y0r};
    endfunction

    function automatic cplx_t cx(input int re, input int im);
        return {16'(im), 16'(re)};
    endfunction

    function automatic logic [71:0] ex(input int y0r, input int y0i, input int y1r, input int y1i);
        return {18'(y1i), 18'(y1r), 18'(y0i), 18'(y0r)};
    endfunction

    task automatic step(input bit sv, input logic [95:0] din, input bit mr);
        logic [71:0] e;
        @(negedge clk);
        bus.s_valid = sv;
        bus.s_data  = din;
        bus.m_ready = mr;
        #1;
        check_eq("s_ready", 64'(bus.s_ready), 64'(!bus.m_valid || mr));
        if (prev_stall) begin
            check_eq("stall_valid", 64'(bus.m_valid), 64'(1));
            check_eq("stall_y0", 64'(bus.m_data[0]), 64'(prev_data[35:0]));
            check_eq("stall_y1", 64'(bus.m_data[1]), 64'(prev_data[71:36]));
        end
        got_out = 1'b0;
        if (bus.m_valid && mr) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(bus.m_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("y0", 64'(bus.m_data[0]), 64'(e[35:0]));
                check_eq("y1", 64'(bus.m_data[1]), 64'(e[71:36]));
            end
            last_out = bus.m_data;
            got_out  = 1'b1;
        end
        accepted = sv && bus.s_ready;
        if (accepted) exp_q.push_back(model(din[31:0], din[63:32], din[95:64]));
        prev_stall = bus.m_valid && !mr;
        prev_data  = bus.m_data;
    endtask

    task automatic directed(input string tag, input cplx_t a, input cplx_t b, input cplx_t w,
                            input logic [71:0] exp);
        int lat;
        bit seen;
        step(1'b1, {w, b, a}, 1'b1);
        check_eq({tag, "_accept"}, 64'(accepted), 64'(1));
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1'b0, '0, 1'b1);
            lat++;
            if (got_out) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'(1));
        check_eq({tag, "_latency"}, 64'(lat), 64'(BFLY_DIT_LATENCY));
        check_eq({tag, "_y0"}, 64'(last_out[35:0]), 64'(exp[35:0]));
        check_eq({tag, "_y1"}, 64'(last_out[71:36]), 64'(exp[71:36]));
    endtask

    initial begin
        int sent;
        int idle_out;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_m_valid", 64'(bus.m_valid), 64'(0));
        check_eq("rst_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;

        directed("t1", cx(1000, -2000), cx(4096, 0), cx(-32768, 0), ex(-3096, -2000, 5096, -2000));
        check_eq("t1_ovf", 64'(overflow), 64'(0));
        directed("t2", cx(0, 0), cx(4096, 0), cx(0, -32768), ex(0, -4096, 0, 4096));
        check_eq("t2_ovf", 64'(overflow), 64'(0));
        directed("t3a", cx(0, 0), cx(1, 0), cx(16384, 0), ex(1, 0, -1, 0));
        directed("t3b", cx(0, 0), cx(-1, 0), cx(16384, 0), ex(0, 0, 0, 0));
        check_eq("t3_ovf", 64'(overflow), 64'(0));
        directed("t4", cx(0, 0), cx(-32768, -32768), cx(-32768, -32768), ex(0, 65535, 0, -65535));
        check_eq("t4_ovf", 64'(overflow), 64'(1));
        directed("t4_legal", cx(1000, -2000), cx(4096, 0), cx(-32768, 0), ex(-3096, -2000, 5096, -2000));
        check_eq("t4_ovf_sticky", 64'(overflow), 64'(1));

        sent = 0;
        for (int c = 0; c < 2000 && sent < 16; c++) begin
            step(1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            if (accepted) sent++;
        end
        check_eq("t5_sent", 64'(sent), 64'(16));
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, '0, 1'b1);
        check_eq("t5_drained", 64'(exp_q.size()), 64'(0));

        for (int i = 0; i < 3; i++) step(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b1);
        check_eq("t6_inflight", 64'(exp_q.size()), 64'(3));
        check_eq("t6_ovf_before", 64'(overflow), 64'(1));
        @(negedge clk);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t6_m_valid", 64'(bus.m_valid), 64'(0));
        check_eq("t6_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        idle_out = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            if (bus.m_valid) idle_out++;
        end
        check_eq("t6_no_stale", 64'(idle_out), 64'(0));
        directed("t6_next", cx(0, 0), cx(1, 0), cx(16384, 0), ex(1, 0, -1, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
